fetch_sequencer: RTL

- Instruction-fetch controller that owns the synchronous-read instruction memory.
- Sequences the program counter and issues one read per cycle.
- Buffers returned 16-bit instructions (`{opcode, op1, op2, funct}` nibbles) behind a valid/ready handshake to decode.
- Handles branch redirects, halt, and exclusive program-load access to the memory write port.

---
 rtl/fetch_sequencer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: PC sequencing, a two-entry fetch buffer, redirects and program load.
// Optional halt-on-opcode-F behaviour is enabled by defining FETCH_HALT_EN.
module fetch_sequencer #(
    parameter int unsigned    DEPTH    = 16,
    parameter int unsigned    AW       = 16,
    parameter logic [AW-1:0]  RESET_PC = '0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          load_en_i,
    input  logic [AW-1:0] load_addr_i,
    input  logic [15:0]   load_data_i,
    output logic          load_ack_o,
    output logic          load_err_o,
    output logic          mem_rd_en_o,
    output logic [AW-1:0] mem_addr_o,
    input  logic [15:0]   mem_rdata_i,
    output logic          mem_wr_en_o,
    output logic [AW-1:0] mem_wr_addr_o,
    output logic [15:0]   mem_wr_data_o,
    output logic          if_valid_o,
    output logic [15:0]   if_instr_o,
    output logic [AW-1:0] if_pc_o,
    input  logic          id_ready_i,
    input  logic          br_taken_i,
    input  logic [AW-1:0] br_target_i,
    output logic          busy_o,
    output logic          halted_o
);

    localparam logic [AW-1:0] PcMask = AW'(DEPTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [1:0]    held_q, held_d;
    logic [15:0]   ent_instr_q [2];
    logic [15:0]   ent_instr_d [2];
    logic [AW-1:0] ent_pc_q [2];
    logic [AW-1:0] ent_pc_d [2];
    logic          infl_q, infl_d;
    logic [AW-1:0] infl_pc_q, infl_pc_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [15:0]   wr_data_q, wr_data_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;

    logic          run, pop, redirect, halt_now, issue;
    logic [2:0]    occ;
    logic [1:0]    hp;

    assign run      = (state_q == StRun);
    assign pop      = (held_q != 2'd0) && id_ready_i;
    assign redirect = run && br_taken_i;
`ifdef FETCH_HALT_EN
    assign halt_now = run && pop && (ent_instr_q[0][15:12] == 4'hF) && !br_taken_i;
    assign halted_o = (state_q == StHalt);
`else
    assign halt_now = 1'b0;
    assign halted_o = 1'b0;
`endif
    assign occ = {1'b0, held_q} + {2'b00, infl_q} - {2'b00, pop};
    // A pending write holds off reads so a load issued with start lands first.
    assign issue = run && !redirect && !halt_now && !wr_en_q && (occ < 3'd2);

    assign mem_rd_en_o   = issue || redirect;
    assign mem_addr_o    = redirect ? (br_target_i & PcMask) : pc_q;
    assign mem_wr_en_o   = wr_en_q;
    assign mem_wr_addr_o = wr_addr_q;
    assign mem_wr_data_o = wr_data_q;
    assign load_ack_o    = ack_q;
    assign load_err_o    = err_q;
    assign if_valid_o    = (held_q != 2'd0);
    assign if_instr_o    = ent_instr_q[0];
    assign if_pc_o       = ent_pc_q[0];
    assign busy_o        = run;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ent_instr_d = ent_instr_q;
        ent_pc_d    = ent_pc_q;
        infl_d      = 1'b0;
        infl_pc_d   = infl_pc_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        ack_d       = 1'b0;
        err_d       = 1'b0;

        hp = held_q - {1'b0, pop};
        if (pop) begin
            ent_instr_d[0] = ent_instr_q[1];
            ent_pc_d[0]    = ent_pc_q[1];
        end
        if (infl_q) begin
            if (hp == 2'd0) begin
                ent_instr_d[0] = mem_rdata_i;
                ent_pc_d[0]    = infl_pc_q;
            end else begin
                ent_instr_d[1] = mem_rdata_i;
                ent_pc_d[1]    = infl_pc_q;
            end
            hp = hp + 2'd1;
        end
        held_d = hp;

        if (mem_rd_en_o) begin
            infl_d    = 1'b1;
            infl_pc_d = mem_addr_o;
            pc_d      = (mem_addr_o + AW'(1)) & PcMask;
        end
        if (redirect || halt_now) begin
            held_d = 2'd0;
        end

        unique case (state_q)
            StIdle, StHalt: begin
                if (start_i) begin
                    state_d = StRun;
                    pc_d    = RESET_PC & PcMask;
                    held_d  = 2'd0;
                    infl_d  = 1'b0;
                end
            end
            StRun: begin
                if (halt_now) begin
                    state_d = StHalt;
                end
            end
            default: state_d = StIdle;
        endcase

        if (load_en_i) begin
            if (!run && (32'(load_addr_i) < DEPTH)) begin
                wr_en_d   = 1'b1;
                wr_addr_d = load_addr_i;
                wr_data_d = load_data_i;
                ack_d     = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            pc_q        <= RESET_PC & PcMask;
            held_q      <= 2'd0;
            ent_instr_q <= '{default: '0};
            ent_pc_q    <= '{default: '0};
            infl_q      <= 1'b0;
            infl_pc_q   <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            held_q      <= held_d;
            ent_instr_q <= ent_instr_d;
            ent_pc_q    <= ent_pc_d;
            infl_q      <= infl_d;
            infl_pc_q   <= infl_pc_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
        end
    end

endmodule
